// File: rtl/alu_issue_if.sv
// Issue/collect bus for alu_issue: IDU request, ALU operand/result bus and WBU response.
// master = the alu_issue side, slave = the surrounding IDU/ALU/WBU.
interface alu_issue_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_src1;
    logic [63:0] in_src2;
    logic [3:0]  in_func;
    logic [3:0]  in_inner;
    logic        in_word;
    logic [4:0]  in_rd;
    logic [63:0] alu_src1;
    logic [63:0] alu_src2;
    logic [3:0]  alu_func;
    logic [3:0]  alu_inner;
    logic [63:0] alu_result;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic [4:0]  out_rd;
    logic        busy;

    modport master (
        input  in_valid, in_src1, in_src2, in_func, in_inner, in_word, in_rd,
        input  alu_result, out_ready,
        output in_ready, alu_src1, alu_src2, alu_func, alu_inner,
        output out_valid, out_result, out_rd, busy
    );

    modport slave (
        output in_valid, in_src1, in_src2, in_func, in_inner, in_word, in_rd,
        output alu_result, out_ready,
        input  in_ready, alu_src1, alu_src2, alu_func, alu_inner,
        input  out_valid, out_result, out_rd, busy
    );
endinterface

// File: rtl/alu_issue.sv
// Multi-cycle issue/collect front end for the combinational ALU (IDLE -> EXEC -> DONE).
// Optional macro ALU_ISSUE_WORD_EN: sign-extend the low 32 result bits for W-ops.
module alu_issue #(
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 16
) (
    input logic         clk,
    input logic         rst,
    alu_issue_if.master bus
);
    localparam int MUL_L = (MUL_LAT < 1) ? 1 : MUL_LAT;
    localparam int DIV_L = (DIV_LAT < 1) ? 1 : DIV_LAT;
    localparam int MAX_L = (MUL_L > DIV_L) ? MUL_L : DIV_L;
    localparam int CW    = $clog2(MAX_L + 1);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_lat;
    logic [63:0]   r_src1;
    logic [63:0]   r_src2;
    logic [3:0]    r_func;
    logic [3:0]    r_inner;
    logic [4:0]    r_rd;
    logic [63:0]   r_result;
    logic [4:0]    r_out_rd;
    logic [63:0]   w_res;
    logic          w_accept;

    assign w_accept = (r_state == S_IDLE) && bus.in_valid;

    always_comb begin
        w_lat = CW'(1);
        case (bus.in_func)
            4'd3:    w_lat = CW'(DIV_L);
            4'd5:    w_lat = CW'(MUL_L);
            default: w_lat = CW'(1);
        endcase
    end

`ifdef ALU_ISSUE_WORD_EN
    logic r_word;

    always_ff @(posedge clk) begin
        if (rst)
            r_word <= 1'b0;
        else if (w_accept)
            r_word <= bus.in_word;
    end

    assign w_res = r_word ? {{32{bus.alu_result[31]}}, bus.alu_result[31:0]} : bus.alu_result;
`else
    logic w_unused_word;
    assign w_unused_word = bus.in_word;
    assign w_res         = bus.alu_result;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_valid) w_next = S_EXEC;
            S_EXEC:  if (r_cnt == CW'(1)) w_next = S_DONE;
            S_DONE:  if (bus.out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Operand registers only load on accept so the ALU sees a frozen bus through EXEC and DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_src1   <= '0;
            r_src2   <= '0;
            r_func   <= '0;
            r_inner  <= '0;
            r_rd     <= '0;
            r_result <= '0;
            r_out_rd <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_src1  <= bus.in_src1;
                        r_src2  <= bus.in_src2;
                        r_func  <= bus.in_func;
                        r_inner <= bus.in_inner;
                        r_rd    <= bus.in_rd;
                        r_cnt   <= w_lat;
                    end
                end
                S_EXEC: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_result <= w_res;
                        r_out_rd <= r_rd;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready   = (r_state == S_IDLE) && !rst;
    assign bus.alu_src1   = r_src1;
    assign bus.alu_src2   = r_src2;
    assign bus.alu_func   = r_func;
    assign bus.alu_inner  = r_inner;
    assign bus.out_valid  = (r_state == S_DONE);
    assign bus.out_result = r_result;
    assign bus.out_rd     = r_out_rd;
    assign bus.busy       = (r_state != S_IDLE);
endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural ALU and a result scoreboard.
module tb_alu_issue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  rd;
        logic [63:0] a;
        logic [3:0]  f;
        int          lat;
    } exp_t;
    exp_t q[$];

    alu_issue_if bus ();

    alu_issue #(.MUL_LAT(3), .DIV_LAT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural ALU; unknown unit codes return 0.
    always_comb begin
        bus.alu_result = 64'd0;
        case (bus.alu_func)
            4'd0: bus.alu_result = bus.alu_src1 + bus.alu_src2;
            4'd3: bus.alu_result = (bus.alu_src2 != 0) ? bus.alu_src1 / bus.alu_src2 : '1;
            4'd4: bus.alu_result = bus.alu_src1 & bus.alu_src2;
            4'd5: bus.alu_result = bus.alu_src1 * bus.alu_src2;
            4'd7: bus.alu_result = bus.alu_src2;
            default: bus.alu_result = 64'd0;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one op at a falling edge; returns at the falling edge after the accepting edge.
    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [3:0] f,
                         input logic w, input logic [4:0] rd, input logic [63:0] res, input int lat);
        exp_t e;
        int k = 0;
        while (!bus.in_ready && k < 50) begin
            @(posedge clk); @(negedge clk); k++;
        end
        chk("issue_ready", bus.in_ready, 1'b1);
        bus.in_valid = 1'b1; bus.in_src1 = a; bus.in_src2 = b;
        bus.in_func = f; bus.in_inner = 4'd0; bus.in_word = w; bus.in_rd = rd;
        e.res = res; e.rd = rd; e.a = a; e.f = f; e.lat = lat;
        q.push_back(e);
        @(posedge clk); @(negedge clk);
        bus.in_valid = 1'b0; bus.in_word = 1'b0;
    endtask

    // Wait for out_valid, check latency and pop/compare the scoreboard entry.
    task automatic collect(input string tag, input bit pulse);
        exp_t e;
        int   k = 0;
        e = q[0];
        while (1) begin
            if (pulse) begin
                bus.in_valid = k[0];
                bus.in_src1  = 64'hBAD0 + 64'(k);
                bus.in_func  = 4'd0;
            end
            @(posedge clk); @(negedge clk); k++;
            if (pulse && !bus.out_valid) begin
                chk({tag, "_src1_hold"}, bus.alu_src1, e.a);
                chk({tag, "_func_hold"}, bus.alu_func, e.f);
                chk({tag, "_no_accept"}, bus.in_ready, 1'b0);
            end
            if (bus.out_valid || k >= 200) break;
        end
        bus.in_valid = 1'b0;
        chk({tag, "_valid"}, bus.out_valid, 1'b1);
        chk({tag, "_latency"}, 64'(k), 64'(e.lat));
        chk({tag, "_result"}, bus.out_result, e.res);
        chk({tag, "_rd"}, bus.out_rd, e.rd);
        void'(q.pop_front());
    endtask

    task automatic handoff(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        chk({tag, "_idle_ready"}, bus.in_ready, 1'b1);
        chk({tag, "_idle_busy"}, bus.busy, 1'b0);
        chk({tag, "_idle_valid"}, bus.out_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] word_exp;
        int seen;
        bus.in_valid = 1'b0; bus.in_src1 = '0; bus.in_src2 = '0; bus.in_func = '0;
        bus.in_inner = '0; bus.in_word = 1'b0; bus.in_rd = '0; bus.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1'b0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_out_result", bus.out_result, 64'd0);
        chk("rst_out_rd", bus.out_rd, 5'd0);
        chk("rst_alu_src1", bus.alu_src1, 64'd0);
        chk("rst_alu_func", bus.alu_func, 4'd0);
        rst = 1'b0;
        #1 chk("rst_release_ready", bus.in_ready, 1'b1);
        @(negedge clk);

        // Add, single-cycle latency
        issue(64'd5, 64'd7, 4'd0, 1'b0, 5'd3, 64'd12, 1);
        chk("add_busy", bus.busy, 1'b1);
        collect("add", 1'b0);
        handoff("add");

        // DIV with in_valid pulses during EXEC
        issue(64'd100, 64'd7, 4'd3, 1'b0, 5'd5, 64'd14, 16);
        collect("div", 1'b1);
        handoff("div");

        // MUL under 5 cycles of backpressure
        bus.out_ready = 1'b0;
        issue(64'd6, 64'd7, 4'd5, 1'b0, 5'd7, 64'd42, 3);
        collect("mul", 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", bus.out_valid, 1'b1);
            chk("bp_result", bus.out_result, 64'd42);
            chk("bp_in_ready", bus.in_ready, 1'b0);
            @(posedge clk); @(negedge clk);
        end
        chk("bp_valid_6th", bus.out_valid, 1'b1);
        handoff("mul");

        // Word op
`ifdef ALU_ISSUE_WORD_EN
        word_exp = 64'hFFFF_FFFF_8000_0000;
`else
        word_exp = 64'h0000_0000_8000_0000;
`endif
        issue(64'h7FFF_FFFF, 64'd1, 4'd0, 1'b1, 5'd11, word_exp, 1);
        collect("word", 1'b0);
        handoff("word");

        // Reset in EXEC cycle 4 of a DIV
        issue(64'd100, 64'd7, 4'd3, 1'b0, 5'd9, 64'd14, 16);
        repeat (3) begin @(posedge clk); @(negedge clk); end
        chk("mid_busy", bus.busy, 1'b1);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("mid_rst_in_ready", bus.in_ready, 1'b0);
        chk("mid_rst_busy", bus.busy, 1'b0);
        chk("mid_rst_src1", bus.alu_src1, 64'd0);
        chk("mid_rst_src2", bus.alu_src2, 64'd0);
        chk("mid_rst_func", bus.alu_func, 4'd0);
        chk("mid_rst_result", bus.out_result, 64'd0);
        rst = 1'b0;
        q.delete();
        #1 chk("mid_rst_ready_after", bus.in_ready, 1'b1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); @(negedge clk);
            if (bus.out_valid) seen++;
        end
        chk("mid_rst_no_valid", 64'(seen), 64'd0);

        // Undefined func code
        issue(64'd123, 64'd456, 4'd9, 1'b0, 5'd30, 64'd0, 1);
        collect("undef", 1'b0);
        chk("undef_func_fwd", bus.alu_func, 4'd9);
        handoff("undef");

        chk("sb_empty", 64'(q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_issue.md
# alu_issue

Multi-cycle issue/collect front end for the EXU's combinational ALU. It accepts one decoded ALU operation from the IDU over a valid/ready handshake and registers the operands and control codes. It holds them stable on the ALU input bus for an op-dependent number of cycles, then captures the ALU result and offers it to the WBU over a second valid/ready handshake. It is the driving end of the ALU's src1/src2/func_control/inner_control → result_out interface.

## Interface
- `MUL_LAT`, 3, cycles the operands are held for func 5 (MUL); values below 1 are treated as 1.
- `DIV_LAT`, 16, cycles the operands are held for func 3 (DIV); values below 1 are treated as 1.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  IDU offers an operation.
- `in_ready`  out  1  block can accept an operation.
- `in_src1`, `in_src2`  in  64  operands.
- `in_func`  in  4  ALU unit select: 0 add, 1 shift, 2 compare, 3 div, 4 logic, 5 mul, 6 auipc, 7 lui.
- `in_inner`  in  4  sub-operation code, passed through unchanged.
- `in_word`  in  1  RV64 W-op flag; see Configuration.
- `in_rd`  in  5  destination register tag.
- `alu_src1`, `alu_src2`  out  64  registered operands to the ALU.
- `alu_func`, `alu_inner`  out  4  registered control codes to the ALU.
- `alu_result`  in  64  combinational ALU result.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  WBU accepts the result.
- `out_result`  out  64  captured result.
- `out_rd`  out  5  tag of the captured result.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, EXEC, DONE.
- **IDLE**
  - `in_ready` = 1.
  - On `in_valid & in_ready`: latch src1, src2, func, inner, word and rd.
  - Load the down-counter with the latency for the op: `DIV_LAT` for func 3, `MUL_LAT` for func 5, 1 for every other code (including the undefined codes 8–15).
  - Next state: EXEC.
- **EXEC**
  - `alu_*` are driven from the latched registers and do not change.
  - The counter decrements every cycle.
  - In the cycle where the counter equals 1: register `alu_result` (after the word transform, if enabled) into `out_result`, register the latched rd into `out_rd`, and go to DONE.
- **DONE**
  - `out_valid` = 1.
  - `out_result` and `out_rd` are stable until accepted.
  - On `out_ready`: go to IDLE.
  - `out_valid` stays high indefinitely while `out_ready` is low.
- `in_ready` is 0 in EXEC and DONE. There is no accept in the same cycle as a DONE→IDLE handoff.
- `alu_*` keep their last latched values while in IDLE and DONE.
- Undefined func codes are issued unchanged; the block forwards whatever the ALU returns (the ALU returns 0 for them).

## Timing
- **Reset values:** state IDLE; `in_ready` 0 during any cycle with `rst` high, otherwise 1. `out_valid` 0, `busy` 0, `out_result` 0, `out_rd` 0, `alu_src1`/`alu_src2` 0, `alu_func`/`alu_inner` 0, counter 0.
- **Latency:** handshake accepted at edge T, EXEC occupies T+1 … T+L, `out_valid` is high from T+L+1. L is the op latency.
- **Throughput:** with `out_ready` held at 1, one op per L+2 cycles.
- **Reset mid-operation:** `rst` in EXEC or DONE abandons the op. No `out_valid` is produced, and all registers return to their reset values on that edge.
- **`in_valid` while not IDLE:** ignored. The IDU must hold its offer until `in_ready`.
- **`out_ready` high outside DONE:** no effect.

## Configuration
- `ALU_ISSUE_WORD_EN`
  - **Defined:** when the latched `in_word` = 1, `out_result` = `{{32{alu_result[31]}}, alu_result[31:0]}`. When `in_word` = 0, the result passes unchanged.
  - **Undefined:** `in_word` is ignored, and `out_result` always equals `alu_result` captured at the end of EXEC.
- Latency and handshake behaviour are identical in both builds.

## Test plan
- **Add:** src1 = 5, src2 = 7, func 0, inner 0, rd 3, `out_ready` = 1 → `out_valid` at T+2, `out_result` = 12, `out_rd` = 3, next `in_ready` at T+3.
- **DIV, `DIV_LAT` = 16:** src1 = 100, src2 = 7, func 3, inner 0 → `alu_*` constant for 16 EXEC cycles, `out_valid` at T+17, `out_result` = 14. `in_valid` pulses during EXEC are not accepted.
- **Backpressure:** MUL 6×7 with `out_ready` low for 5 DONE cycles → `out_result` = 42 stable and `in_ready` = 0 for all 5 cycles. Accept on the 6th cycle, then IDLE.
- **Word op:** add 0x7FFFFFFF + 1, `in_word` = 1 → `out_result` = 0xFFFFFFFF80000000 with `ALU_ISSUE_WORD_EN`, 0x0000000080000000 without.
- **Reset mid-DIV:** `rst` high in EXEC cycle 4 for one cycle → no `out_valid` ever, all `alu_*` 0, `in_ready` = 1 the cycle after `rst` falls.
- **Undefined func 9:** any operands → latency 1, `out_result` = 0.
